demux_1to2_buf: RTL

//   Buffered 1-to-2 byte demultiplexer: the write-side counterpart of the 8-bit 2:1 datapath mux.
//   It accepts one byte per cycle from the internal data bus under a valid/ready handshake.
//   in_sel steers each byte to destination A (0) or destination B (1), for example register A or register B.

---
 rtl/demux_1to2_buf_if.sv | 26 ++
 rtl/demux_1to2_buf.sv | 114 +++++++++++
 2 files changed

// File: rtl/demux_1to2_buf_if.sv
// Bus bundle for demux_1to2_buf: input handshake plus the two destination channels.
// master drives bytes in and consumes channels; slave is the demux itself.
interface demux_1to2_buf_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_data;
    logic             a_valid;
    logic             a_ready;
    logic [WIDTH-1:0] b_data;
    logic             b_valid;
    logic             b_ready;

    modport master (
        output in_data, in_sel, in_valid, a_ready, b_ready,
        input  in_ready, a_data, a_valid, b_data, b_valid
    );

    modport slave (
        input  in_data, in_sel, in_valid, a_ready, b_ready,
        output in_ready, a_data, a_valid, b_data, b_valid
    );
endinterface

// File: rtl/demux_1to2_buf.sv
// Buffered 1-to-2 byte demultiplexer with a 2-entry in-order buffer per destination.
// Define DEMUX_CNT_EN to add 8-bit wrapping per-channel delivery counters (a_count/b_count).
module demux_1to2_buf #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    demux_1to2_buf_if.slave      bus
`ifdef DEMUX_CNT_EN
    ,
    output logic [7:0]           a_count,
    output logic [7:0]           b_count
`endif
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_t;

    occ_t             a_state, a_next;
    occ_t             b_state, b_next;
    logic [WIDTH-1:0] a_mem [2];
    logic [WIDTH-1:0] b_mem [2];
    logic             a_wptr, a_rptr;
    logic             b_wptr, b_rptr;
    logic             in_ready;
    logic             a_valid, b_valid;
    logic             a_push, a_pop;
    logic             b_push, b_pop;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_state <= EMPTY;
            b_state <= EMPTY;
        end else begin
            a_state <= a_next;
            b_state <= b_next;
        end
    end

    // Next-state logic
    always_comb begin
        a_next = a_state;
        case (a_state)
            EMPTY:   if (a_push) a_next = ONE;
            ONE:     if (a_push && !a_pop) a_next = FULL;
                     else if (!a_push && a_pop) a_next = EMPTY;
            FULL:    if (a_pop) a_next = ONE;
            default: a_next = EMPTY;
        endcase
    end

    always_comb begin
        b_next = b_state;
        case (b_state)
            EMPTY:   if (b_push) b_next = ONE;
            ONE:     if (b_push && !b_pop) b_next = FULL;
                     else if (!b_push && b_pop) b_next = EMPTY;
            FULL:    if (b_pop) b_next = ONE;
            default: b_next = EMPTY;
        endcase
    end

    // Output logic; in_ready looks only at registered state, so a pop never frees space the same cycle
    always_comb begin
        in_ready    = bus.in_sel ? (b_state != FULL) : (a_state != FULL);
        a_valid     = (a_state != EMPTY);
        b_valid     = (b_state != EMPTY);
        a_push      = bus.in_valid & in_ready & ~bus.in_sel;
        b_push      = bus.in_valid & in_ready &  bus.in_sel;
        a_pop       = a_valid & bus.a_ready;
        b_pop       = b_valid & bus.b_ready;
        bus.in_ready = in_ready;
        bus.a_valid  = a_valid;
        bus.b_valid  = b_valid;
        bus.a_data   = a_valid ? a_mem[a_rptr] : '0;
        bus.b_data   = b_valid ? b_mem[b_rptr] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_wptr <= 1'b0;
            a_rptr <= 1'b0;
            b_wptr <= 1'b0;
            b_rptr <= 1'b0;
        end else begin
            if (a_push) a_wptr <= ~a_wptr;
            if (a_pop)  a_rptr <= ~a_rptr;
            if (b_push) b_wptr <= ~b_wptr;
            if (b_pop)  b_rptr <= ~b_rptr;
        end
    end

    // Entries need no reset: they are only observed once the state says they hold a byte
    always_ff @(posedge clk) begin
        if (a_push) a_mem[a_wptr] <= bus.in_data;
        if (b_push) b_mem[b_wptr] <= bus.in_data;
    end

`ifdef DEMUX_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_count <= '0;
            b_count <= '0;
        end else begin
            if (a_pop) a_count <= a_count + 8'd1;
            if (b_pop) b_count <= b_count + 8'd1;
        end
    end
`endif

endmodule
